coin_dispenser: RTL

//  Change-return transmitter: given a change amount, ejects coins to the coin-return mechanism
//  as timed per-denomination pulses. It is the output-side counterpart of the coin intake path.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/coin_stock_counter.sv | 40 ++++
 rtl/coin_dispenser.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the change-return path: FSM states, default coin
// values and the 8-bit stock ceiling with a saturating add helper.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int COIN1_DEF = 1;
    localparam int COIN2_DEF = 2;
    localparam int COIN5_DEF = 5;

    localparam logic [7:0] STOCK_MAX = 8'd255;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? STOCK_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/coin_stock_counter.sv
// Per-denomination coin stock: saturating refill, decrement-if-nonzero take; 1-cycle update.
// No backpressure: refill and take are trusted to be mutually exclusive by the caller.
module coin_stock_counter
    import vend_pkg::*;
#(
    parameter int INIT_STOCK = 10,
    parameter int REFILL_QTY = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refill,
    input  logic       take,
    output logic [7:0] count,
    output logic       nonzero
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (refill) begin
            count_d = sat_add8(count_q, 8'(REFILL_QTY));
        end else if (take && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'(INIT_STOCK);
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != 8'd0);

endmodule

// File: rtl/coin_dispenser.sv
// Greedy change-return FSM driving timed eject pulses; first eject 2 cycles after start,
// pulse period PULSE+GAP+1. Start/refill while busy are dropped (no queueing).
module coin_dispenser
    import vend_pkg::*;
#(
    parameter int COIN1_VALUE  = COIN1_DEF,
    parameter int COIN2_VALUE  = COIN2_DEF,
    parameter int COIN5_VALUE  = COIN5_DEF,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int INIT_STOCK   = 10,
    parameter int REFILL_QTY   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       refill1,
    input  logic       refill2,
    input  logic       refill5,
    output logic       busy,
    output logic       done,
    output logic       short_change,
    output logic [7:0] remaining,
    output logic       eject1,
    output logic       eject2,
    output logic       eject5,
    output logic [7:0] stock1,
    output logic [7:0] stock2,
    output logic [7:0] stock5
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Bit order for take/eject/nonzero vectors: [0]=coin1, [1]=coin2, [2]=coin5.
    state_t          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      eject_q, eject_d;
    logic [2:0]      take;
    logic [2:0]      nonzero;
    logic            refill_ok;

    assign refill_ok = (state_q == ST_IDLE);

    coin_stock_counter #(.INIT_STOCK(INIT_STOCK), .REFILL_QTY(REFILL_QTY)) u_stock1 (
        .clk(clk), .rst(rst), .refill(refill1 && refill_ok), .take(take[0]),
        .count(stock1), .nonzero(nonzero[0])
    );
    coin_stock_counter #(.INIT_STOCK(INIT_STOCK), .REFILL_QTY(REFILL_QTY)) u_stock2 (
        .clk(clk), .rst(rst), .refill(refill2 && refill_ok), .take(take[1]),
        .count(stock2), .nonzero(nonzero[1])
    );
    coin_stock_counter #(.INIT_STOCK(INIT_STOCK), .REFILL_QTY(REFILL_QTY)) u_stock5 (
        .clk(clk), .rst(rst), .refill(refill5 && refill_ok), .take(take[2]),
        .count(stock5), .nonzero(nonzero[2])
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        eject_d = eject_q;
        take    = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // COIN1 > 0, so rem == 0 never matches and falls through to FINISH.
                if ((rem_q >= 8'(COIN5_VALUE)) && nonzero[2]) begin
                    take  = 3'b100;
                    rem_d = rem_q - 8'(COIN5_VALUE);
                end else if ((rem_q >= 8'(COIN2_VALUE)) && nonzero[1]) begin
                    take  = 3'b010;
                    rem_d = rem_q - 8'(COIN2_VALUE);
                end else if ((rem_q >= 8'(COIN1_VALUE)) && nonzero[0]) begin
                    take  = 3'b001;
                    rem_d = rem_q - 8'(COIN1_VALUE);
                end
                if (take != 3'b000) begin
                    eject_d = take;
                    timer_d = TW'(PULSE_CYCLES - 1);
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    eject_d = 3'b000;
                    timer_d = TW'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                eject_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= 8'd0;
            timer_q <= '0;
            eject_q <= 3'b000;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            eject_q <= eject_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign short_change = done && (rem_q != 8'd0);
    assign remaining    = rem_q;
    assign eject1       = eject_q[0];
    assign eject2       = eject_q[1];
    assign eject5       = eject_q[2];

endmodule
